instruction_fetch: RTL and testbench

Instruction fetch unit: the requesting side of the program memory's combinational read port. Holds the program counter, drives the read address, and captures the returned instruction into a one-entry instruction register (IR). The IR is handed to decode over a valid/ready handshake. Accepts branch redirects from execute, flushing the wrong-path IR entry.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/program_counter.sv | 29 ++
 rtl/instruction_fetch.sv | 67 ++++++
 tb/tb_instruction_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared widths and the fetch packet carried from fetch to decode.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 4;
  localparam int DEFAULT_INSTR_WIDTH = 12;

  typedef struct packed {
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// program_counter : pc register with load (priority), increment and hold.
// Revision: 1.0
// ============================================================================
module program_counter #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Increment wraps naturally at 2^ADDR_WIDTH; no overflow flag is kept.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// instruction_fetch : drives program memory from the pc and holds a one-entry
// instruction register handed to decode over valid/ready; branches flush it.
// Revision: 1.0
// ============================================================================
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   n_reset,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   enable,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [INSTR_WIDTH-1:0] ir_instr,
  output logic [ADDR_WIDTH-1:0]  ir_pc
);

  logic [ADDR_WIDTH-1:0] pc;
  logic                  slot_free;
  logic                  fetch;
  fetch_pkt_t            ir;

  assign slot_free = !ir_valid || ir_ready;
  assign fetch     = enable && !branch_valid && slot_free;

  program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_program_counter (
    .clk        (clk),
    .n_reset    (n_reset),
    .inc        (fetch),
    .load       (branch_valid),
    .load_value (branch_target),
    .pc         (pc)
  );

  // A branch kills the IR entry whether or not decode takes it this edge;
  // instr/pc contents are left stale since they are ignored while invalid.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ir_valid <= 1'b0;
      ir       <= '0;
    end else if (branch_valid) begin
      ir_valid <= 1'b0;
    end else if (fetch) begin
      ir_valid <= 1'b1;
      ir.instr <= imem_instr;
      ir.pc    <= pc;
    end else if (ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

  assign imem_addr = pc;
  assign ir_instr  = ir.instr;
  assign ir_pc     = ir.pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// tb_instruction_fetch : directed scenarios plus random traffic against a
// transaction-level model of the fetch unit. Revision: 1.0
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [3:0]  imem_addr;
  logic [11:0] imem_instr;
  logic        enable;
  logic        branch_valid;
  logic [3:0]  branch_target;
  logic        ir_valid;
  logic        ir_ready;
  logic [11:0] ir_instr;
  logic [3:0]  ir_pc;

  int checks = 0;
  int errors = 0;

  // model state
  int m_pc;
  bit m_valid;
  int m_instr;
  int m_irpc;
  int accepted_q[$];

  always #5 clk = ~clk;

  assign imem_instr = 12'h100 + {8'h00, imem_addr};

  instruction_fetch dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .enable        (enable),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_instr      (ir_instr),
    .ir_pc         (ir_pc)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc    = 0;
    m_valid = 0;
  endfunction

  // One edge of the fetch unit described in terms of its transactions.
  function automatic void model_edge(input bit en, input bit br, input int tgt, input bit rdy);
    if (m_valid && rdy) accepted_q.push_back(m_irpc);
    if (br) begin
      m_pc    = tgt % 16;
      m_valid = 0;
    end else if (en && (!m_valid || rdy)) begin
      m_instr = 'h100 + m_pc;
      m_irpc  = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 16;
    end else if (rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic compare_model();
    check("imem_addr", int'(imem_addr), m_pc);
    check("ir_valid", int'(ir_valid), int'(m_valid));
    if (m_valid) begin
      check("ir_instr", int'(ir_instr), m_instr);
      check("ir_pc", int'(ir_pc), m_irpc);
    end
  endtask

  // Called one time unit after a rising edge; returns the same phase.
  task automatic cycle(input bit en, input bit br, input int tgt, input bit rdy);
    enable        = en;
    branch_valid  = br;
    branch_target = 4'(tgt);
    ir_ready      = rdy;
    @(posedge clk);
    model_edge(en, br, tgt, rdy);
    #1;
    compare_model();
  endtask

  initial begin
    int n_before;
    int guard;
    n_reset       = 1'b0;
    enable        = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    ir_ready      = 1'b0;
    model_reset();

    // reset state
    @(posedge clk);
    #1;
    check("rst_pc", int'(imem_addr), 0);
    check("rst_valid", int'(ir_valid), 0);
    check("rst_instr", int'(ir_instr), 0);
    check("rst_irpc", int'(ir_pc), 0);
    #2 n_reset = 1'b1;
    @(posedge clk);
    #1;
    compare_model();

    // steady-state stream from reset
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 1);
      check("seq_pc", int'(ir_pc), i);
      check("seq_instr", int'(ir_instr), 'h100 + i);
    end

    // run through the top address and wrap
    for (int i = 4; i < 16; i++) cycle(1, 0, 0, 1);
    check("top_instr", int'(ir_instr), 'h10F);
    check("top_pc", int'(ir_pc), 15);
    cycle(1, 0, 0, 1);
    check("wrap_instr", int'(ir_instr), 'h100);
    check("wrap_pc", int'(ir_pc), 0);

    // backpressure holds IR and pc
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("bp_start", int'(ir_instr), 'h102);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0);
      check("bp_hold_instr", int'(ir_instr), 'h102);
      check("bp_hold_pc", int'(imem_addr), 3);
    end
    cycle(1, 0, 0, 1);
    check("bp_release", int'(ir_instr), 'h103);

    // branch while IR is stalled discards that entry
    cycle(1, 0, 0, 1);
    check("br_pre_pc", int'(ir_pc), 4);
    n_before = accepted_q.size();
    cycle(1, 1, 9, 0);
    check("br_bubble", int'(ir_valid), 0);
    cycle(1, 0, 0, 1);
    check("br_instr", int'(ir_instr), 'h109);
    check("br_irpc", int'(ir_pc), 9);
    for (int i = n_before; i < accepted_q.size(); i++)
      check("br_discard", int'(accepted_q[i] == 4), 0);

    // drain with fetch disabled, then resume at held pc
    cycle(0, 0, 0, 1);
    check("drain_valid", int'(ir_valid), 0);
    check("drain_pc", int'(imem_addr), 10);
    cycle(0, 0, 0, 1);
    check("drain_hold_pc", int'(imem_addr), 10);
    cycle(1, 0, 0, 1);
    check("resume_instr", int'(ir_instr), 'h10A);

    // branch to the current pc refetches after a bubble
    cycle(1, 1, m_pc, 1);
    cycle(1, 0, 0, 1);

    // asynchronous reset between edges
    guard = 0;
    while (int'(imem_addr) != 6 && guard < 20) begin
      cycle(1, 0, 0, 1);
      guard++;
    end
    check("reach_pc6", int'(imem_addr), 6);
    #1 n_reset = 1'b0;
    model_reset();
    #1;
    check("arst_pc", int'(imem_addr), 0);
    check("arst_valid", int'(ir_valid), 0);
    #1 n_reset = 1'b1;
    cycle(1, 0, 0, 1);
    check("arst_first_instr", int'(ir_instr), 'h100);
    check("arst_first_pc", int'(ir_pc), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom_range(6, 0) == 0,
            int'($urandom_range(15, 0)), $urandom_range(4, 0) > 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
